// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes, receive FSM states and
// the data-width limits honoured by both the receiver and transmitter.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int UART_WIDTH_MIN = 5;
    localparam int UART_WIDTH_MAX = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_DONE
    } rx_state_e;

    // Mode 2'b11 is deliberately treated like "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_parity_acc.sv
// Running XOR / all-zero accumulator over a bit stream. Shared by the
// receive checker and the transmit parity generator.
module uart_parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic parity_o,
    output logic all_zero_o
);

    logic parity_q;
    logic all_zero_q;

    // Clear has priority; otherwise fold each enabled bit into both trackers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q   <= 1'b0;
            all_zero_q <= 1'b1;
        end else if (clr_i) begin
            parity_q   <= 1'b0;
            all_zero_q <= 1'b1;
        end else if (en_i) begin
            parity_q   <= parity_q ^ bit_i;
            all_zero_q <= all_zero_q & ~bit_i;
        end
    end

    assign parity_o   = parity_q;
    assign all_zero_o = all_zero_q;

endmodule

// File: rtl/uart_frame_checker.sv
// Receive-side frame checker: assembles LSB-first data from bit-centre
// samples, checks parity and stop bits, flags line break, and hands the
// word plus error flags on with a one-cycle valid pulse.
module uart_frame_checker
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_en,
    input  logic             RX_data,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             stop_bit_err,
    output logic             break_det,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] bit_sel;
    logic [1:0]       pmode_q;
    logic             two_stop_q;
    logic             stop_err_q, stop_err_d;
    logic             brk_q, brk_d;
    logic [WIDTH-1:0] data_out_q;
    logic             parity_err_q, stop_bit_err_q, break_det_q;
    logic             acc_parity, acc_all_zero;
    logic             done_entry;
    logic             frame_parity_err;

    // Parity and zero tracking cover data bits plus the parity bit, never stop bits.
    uart_parity_acc u_parity_acc (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == ST_IDLE),
        .en_i       (sample_en && ((state_q == ST_DATA) || (state_q == ST_PARITY))),
        .bit_i      (RX_data),
        .parity_o   (acc_parity),
        .all_zero_o (acc_all_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE and samples in IDLE have no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DATA;
            ST_DATA:   if (sample_en && (cnt_q == CNT_LAST))
                           state_d = parity_enabled(pmode_q) ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (sample_en) state_d = ST_STOP1;
            ST_STOP1:  if (sample_en) state_d = two_stop_q ? ST_STOP2 : ST_DONE;
            ST_STOP2:  if (sample_en) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        data_valid = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
    end

    // Write RX_data into the bit addressed by the counter (LSB first).
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            bit_sel[i] = (cnt_q == CNT_W'(i));
        end
        shift_d = (shift_q & ~bit_sel) | (bit_sel & {WIDTH{RX_data}});
    end

    // Stop/break flags as they stand after the current stop sample.
    always_comb begin
        stop_err_d = stop_err_q;
        brk_d      = brk_q;
        if (sample_en && (state_q == ST_STOP1)) begin
            stop_err_d = ~RX_data;
            brk_d      = ~RX_data & acc_all_zero;
        end else if (sample_en && (state_q == ST_STOP2)) begin
            stop_err_d = stop_err_q | ~RX_data;
        end
    end

    assign done_entry       = (state_q != ST_DONE) && (state_d == ST_DONE);
    assign frame_parity_err = ((pmode_q == PAR_EVEN) &&  acc_parity) ||
                              ((pmode_q == PAR_ODD)  && ~acc_parity);

    // Frame datapath; the result registers load on entry to DONE so they
    // change together with the data_valid pulse and hold until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q          <= '0;
            shift_q        <= '0;
            pmode_q        <= PAR_NONE;
            two_stop_q     <= 1'b0;
            stop_err_q     <= 1'b0;
            brk_q          <= 1'b0;
            data_out_q     <= '0;
            parity_err_q   <= 1'b0;
            stop_bit_err_q <= 1'b0;
            break_det_q    <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                cnt_q      <= '0;
                stop_err_q <= 1'b0;
                brk_q      <= 1'b0;
                if (start) begin
                    pmode_q    <= parity_mode;
                    two_stop_q <= two_stop;
                end
            end else begin
                stop_err_q <= stop_err_d;
                brk_q      <= brk_d;
            end
            if ((state_q == ST_DATA) && sample_en) begin
                shift_q <= shift_d;
                cnt_q   <= cnt_q + 1'b1;
            end
            if (done_entry) begin
                data_out_q     <= shift_q;
                parity_err_q   <= frame_parity_err;
                stop_bit_err_q <= stop_err_d;
                break_det_q    <= brk_d;
            end
        end
    end

    assign data_out     = data_out_q;
    assign parity_err   = parity_err_q;
    assign stop_bit_err = stop_bit_err_q;
    assign break_det    = break_det_q;

endmodule
